// File: rtl/timer_sequencer.sv
// Control sequencer for a 00.00-99.00 stopwatch/timer: debounces the start/stop
// button and steps the datapath through load, run, pause and done phases.
module timer_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_TICKS     = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       startstop,
  input  logic [1:0] mode,
  input  logic       at_zero,
  input  logic       at_max,
  output logic       count_enable,
  output logic       up,
  output logic       load,
  output logic [1:0] load_mode,
  output logic       done,
  output logic       blink
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_level;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_db_hit;
  logic            w_press;
  logic            w_term;
  logic [1:0]      r_load_mode;
  logic            r_up;
  logic            r_done;
  logic [BL_W-1:0] r_bl_cnt;
  logic            r_blink;

  // The counter holds the length of the current run of samples that disagree
  // with the accepted level; any agreeing sample restarts it.
  assign w_db_hit = (startstop != r_level) && (r_db_cnt == DB_LAST);
  assign w_press  = w_db_hit & startstop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else if (startstop == r_level) begin
      r_db_cnt <= '0;
    end else if (w_db_hit) begin
      r_level  <= startstop;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_term = (r_up & at_max) | (~r_up & at_zero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  // Terminal beats press in RUN; a mode change beats press in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  w_next = S_IDLE;
      S_IDLE: begin
        if (mode != r_load_mode) w_next = S_LOAD;
        else if (w_press)        w_next = S_RUN;
      end
      S_RUN: begin
        if (w_term)       w_next = S_DONE;
        else if (w_press) w_next = S_PAUSE;
      end
      S_PAUSE: if (w_press) w_next = S_RUN;
      S_DONE:  if (w_press) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_comb begin
    load         = (r_state == S_LOAD);
    count_enable = (r_state == S_RUN) & tick & ~w_term;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_mode <= 2'b00;
      r_up        <= 1'b1;
    end else if (r_state == S_LOAD) begin
      r_load_mode <= mode;
      r_up        <= ~mode[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_done <= 1'b0;
    else        r_done <= (w_next == S_DONE);
  end

  // Keyed off the next state so blink is already low in the first clk after DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bl_cnt <= '0;
      r_blink  <= 1'b0;
    end else if (w_next != S_DONE) begin
      r_bl_cnt <= '0;
      r_blink  <= 1'b0;
    end else if ((r_state == S_DONE) && tick) begin
      if (r_bl_cnt == BL_LAST) begin
        r_bl_cnt <= '0;
        r_blink  <= ~r_blink;
      end else begin
        r_bl_cnt <= r_bl_cnt + BL_W'(1);
      end
    end
  end

  assign up        = r_up;
  assign load_mode = r_load_mode;
  assign done      = r_done;
  assign blink     = r_blink;

endmodule
